// File: rtl/jtopl_pkg.sv
// Shared counts and index-width helper for the FM operator-slot pipeline.
// Combinational constants only; no latency, no flow control.
package jtopl_pkg;

  localparam int DEF_GROUPS     = 3;
  localparam int DEF_CH_PER_GRP = 3;
  localparam int DEF_OPS        = 2;

  // Index width for a range of n values, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_SUBS  = DEF_OPS * DEF_CH_PER_GRP;
  localparam int DEF_SLOTS = DEF_GROUPS * DEF_SUBS;
  localparam int DEF_CHANS = DEF_GROUPS * DEF_CH_PER_GRP;

endpackage

// File: rtl/jtopl_slot_dec.sv
// Maps (group, subslot) to operator, global channel and binary slot index.
// Purely combinational; no latency, no backpressure.
module jtopl_slot_dec
  import jtopl_pkg::*;
#(
  parameter int GROUPS     = DEF_GROUPS,
  parameter int CH_PER_GRP = DEF_CH_PER_GRP,
  parameter int OPS        = DEF_OPS,
  localparam int SUBS  = OPS * CH_PER_GRP,
  localparam int SLOTS = GROUPS * SUBS,
  localparam int CHANS = GROUPS * CH_PER_GRP,
  localparam int GW    = clog2_min1(GROUPS),
  localparam int SW    = clog2_min1(SUBS),
  localparam int OW    = clog2_min1(OPS),
  localparam int CW    = clog2_min1(CHANS),
  localparam int IW    = clog2_min1(SLOTS)
) (
  input  logic [GW-1:0] group,
  input  logic [SW-1:0] subslot,
  output logic [OW-1:0] op,
  output logic [CW-1:0] ch,
  output logic [IW-1:0] slot_idx
);

  logic [31:0] g32;
  logic [31:0] s32;

  assign g32 = 32'(group);
  assign s32 = 32'(subslot);

  // Channels of one operator are contiguous inside a group.
  assign op       = OW'(s32 / 32'(CH_PER_GRP));
  assign ch       = CW'(g32 * 32'(CH_PER_GRP) + s32 % 32'(CH_PER_GRP));
  assign slot_idx = IW'(g32 * 32'(SUBS) + s32);

endmodule

// File: rtl/jtopl_slot_seq.sv
// Operator-slot sequencer: group/subslot counters, one-hot ring, frame counter.
// One clk from a cen to new outputs; cen=0 freezes all state, sync restarts at slot 0.
module jtopl_slot_seq
  import jtopl_pkg::*;
#(
  parameter int GROUPS     = DEF_GROUPS,
  parameter int CH_PER_GRP = DEF_CH_PER_GRP,
  parameter int OPS        = DEF_OPS,
  parameter int FRMW       = 8,
  localparam int SUBS  = OPS * CH_PER_GRP,
  localparam int SLOTS = GROUPS * SUBS,
  localparam int CHANS = GROUPS * CH_PER_GRP,
  localparam int GW    = clog2_min1(GROUPS),
  localparam int SW    = clog2_min1(SUBS),
  localparam int OW    = clog2_min1(OPS),
  localparam int CW    = clog2_min1(CHANS),
  localparam int IW    = clog2_min1(SLOTS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic             sync,
  output logic             zero,
  output logic             last,
  output logic [GW-1:0]    group,
  output logic [GW-1:0]    next_group,
  output logic [SW-1:0]    subslot,
  output logic [OW-1:0]    op,
  output logic [CW-1:0]    ch,
  output logic [IW-1:0]    slot_idx,
  output logic [SLOTS-1:0] slot,
  output logic [FRMW-1:0]  frame
);

  if (OPS != 2 && OPS != 4) begin : g_bad_ops
    $error("jtopl_slot_seq: OPS must be 2 or 4");
  end
  if (GROUPS < 1 || CH_PER_GRP < 1 || FRMW < 1) begin : g_bad_count
    $error("jtopl_slot_seq: GROUPS, CH_PER_GRP and FRMW must be at least 1");
  end

  logic          sub_end;
  logic          frm_end;
  logic          restart;
  logic [SW-1:0] nxt_sub;
  logic [OW-1:0] nxt_op;
  logic [CW-1:0] nxt_ch;
  logic [IW-1:0] nxt_idx;

  assign sub_end = (subslot == SW'(SUBS - 1));
  assign frm_end = sub_end && (group == GW'(GROUPS - 1));
  assign restart = sync || frm_end;

  always_comb begin
    nxt_sub    = subslot + SW'(1);
    next_group = group;
    if (restart) begin
      nxt_sub    = '0;
      next_group = '0;
    end else if (sub_end) begin
      nxt_sub    = '0;
      next_group = group + GW'(1);
    end
  end

  // Decoding the next state lets every output update on the same edge.
  jtopl_slot_dec #(
    .GROUPS     (GROUPS),
    .CH_PER_GRP (CH_PER_GRP),
    .OPS        (OPS)
  ) u_dec (
    .group    (next_group),
    .subslot  (nxt_sub),
    .op       (nxt_op),
    .ch       (nxt_ch),
    .slot_idx (nxt_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      group    <= '0;
      subslot  <= '0;
      op       <= '0;
      ch       <= '0;
      slot_idx <= '0;
      slot     <= SLOTS'(1);
      frame    <= '0;
    end else if (cen) begin
      group    <= next_group;
      subslot  <= nxt_sub;
      op       <= nxt_op;
      ch       <= nxt_ch;
      slot_idx <= nxt_idx;
      slot     <= restart ? SLOTS'(1) : {slot[SLOTS-2:0], slot[SLOTS-1]};
      // A restart requested on the last slot swallows the frame increment.
      if (frm_end && !sync) begin
        frame <= frame + FRMW'(1);
      end
    end
  end

  assign zero = (slot_idx == '0);
  assign last = (slot_idx == IW'(SLOTS - 1));

endmodule

// File: doc/jtopl_slot_seq.md
# jtopl_slot_seq

Parametrised operator-slot sequencer for the FM pipeline. Steps through every operator slot of a frame in pipeline order on each clock enable. Publishes group, subslot, operator index, channel, binary slot index, one-hot slot, frame-end strobe and a wrapping frame counter. Generalises the fixed 18-slot, 2-operator counter to any group, channel and operator count, and adds a synchronous frame restart.

## Interface
Parameters:
- GROUPS, 3: channel groups per frame.
- CH_PER_GRP, 3: channels per group.
- OPS, 2: operators per channel; 2 and 4 are supported.
- FRMW, 8: frame counter width.
- Derived values: SUBS = OPS*CH_PER_GRP; SLOTS = GROUPS*SUBS; CHANS = GROUPS*CH_PER_GRP. Each index width is clog2 of its range, minimum 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- cen  in  1  clock enable; state advances only when cen=1
- sync  in  1  restart request; sampled only when cen=1
- zero  out  1  current slot is slot 0
- last  out  1  current slot is slot SLOTS-1
- group  out  GW  current group
- next_group  out  GW  group that the next cen will load, sync included
- subslot  out  SW  position inside the group, 0..SUBS-1
- op  out  OW  operator index, subslot / CH_PER_GRP
- ch  out  CW  global channel, group*CH_PER_GRP + subslot%CH_PER_GRP
- slot_idx  out  IW  binary slot index, 0..SLOTS-1
- slot  out  SLOTS  one-hot active slot
- frame  out  FRMW  completed-frame counter

## Operation
- Order inside a group: all channels of op 0, then all channels of op 1, and so on. With 3/3/2 this gives subslots 0-2 as op 0 and 3-5 as op 1.
- Next-state rules, applied on cen=1 in priority order:
  - sync=1: load slot 0. slot_idx=0, group=0, subslot=0, op=0, ch=0, slot=1. frame does not change.
  - subslot=SUBS-1 and group=GROUPS-1: wrap to slot 0 and increment frame, modulo 2^FRMW.
  - subslot=SUBS-1: subslot=0, group+1.
  - otherwise: subslot+1.
- slot rotates left by one per step and reloads 1 on wrap or sync. It must never hold zero bits set or more than one bit set.
- op, ch and slot_idx are registered. They are computed from the next-state values, so all outputs change together in the same cycle.
- zero and last are decoded combinationally from the registers. next_group is combinational from the current state and sync.
- cen=0: every register holds. sync is ignored.

## Timing
- Reset values, held while rst_n=0: group=0, subslot=0, op=0, ch=0, slot_idx=0, slot=1, frame=0. Hence zero=1 and last=0.
- Reset is asserted asynchronously. Release is synchronous to clk; the first advance happens on the first cen after release.
- Latency: one clk from a cen edge to the new slot on every output.
- A frame is exactly SLOTS cen pulses when no sync occurs.
- sync on the cen where last=1: slot 0 is loaded and frame does not increment.
- Back-to-back sync: the sequencer stays at slot 0.
- rst_n low mid-frame: all state clears immediately. frame returns to 0.

## Structure
- Shared package jtopl_pkg holds: the default counts (GROUPS=3, CH_PER_GRP=3, OPS=2), a clog2-with-minimum-1 function, and the localparams derived from them.
- One sub-module, jtopl_slot_dec: combinational. Maps (group, subslot) to op, ch and slot_idx. It is instanced once on the next-state path. The top module holds the counters, the one-hot ring and the frame counter.
- Any parameter outside 2/4 for OPS, or any count of 0, must stop elaboration with an error.

## Test plan
- Reset then 18 cen pulses, default parameters: slot_idx goes 0..17 then back to 0. op=1 exactly at subslots 3-5. ch goes 0,1,2,0,1,2,3,4,5,3,4,5,... frame=1 after the wrap.
- OPS=4, GROUPS=3, CH_PER_GRP=3, over 36 cen pulses: op steps 0,0,0,1,1,1,2,2,2,3,3,3 in every group. last=1 only at slot_idx 35. next_group changes only at subslot 11.
- cen asserted 1 cycle in 3 over 2 frames: outputs hold between enables. Total advance is 36 slots. frame=2.
- sync at slot_idx 7: next value is slot_idx=0 and slot=1. frame is unchanged. sync with cen=0 has no effect.
- rst_n pulsed low at slot_idx 10 with frame=5: all outputs return to their reset values without waiting for a clk edge.
- Free-run 2^FRMW+1 frames: frame wraps 255 to 0 to 1. A checker confirms slot is one-hot and equals 1<<slot_idx on every cycle.
